// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store engine with valid/ready data port, writeback and fault reporting
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RD_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_branch_ref,
  input  logic              branch_ref_global,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W/8-1:0] mem_req_be,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_clr
);
  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] op_addr;
  logic [NB-1:0]     op_be;
  logic [DATA_W-1:0] op_wdata;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_signed;
  logic [RD_W-1:0]   op_rd;
  logic [TW-1:0]     tmo_cnt;

  logic              tag_ok, is_nop, illegal, tmo_hit;
  logic [NB-1:0]     bem;
  logic [DATA_W-1:0] wdata_rep, shifted, keep, ld_ext;
  logic              sbit;

  assign tag_ok   = (in_branch_ref == branch_ref_global);
  assign is_nop   = ~in_load & ~in_store;
  assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt >= TW'(TIMEOUT - 1));
  assign in_ready = (state == S_IDLE);
  assign stall    = in_valid & ~in_ready;
  assign fault    = (state == S_FAULT);

  assign mem_req_valid = (state == S_REQ);
  assign mem_req_we    = op_we;
  assign mem_req_addr  = {op_addr[ADDR_W-1:LW], LW'(0)};
  assign mem_req_be    = op_be;
  assign mem_req_wdata = op_wdata;

  // Accept-time decode: alignment check, byte-enable mask and lane replication
  always_comb begin
    illegal   = in_load & in_store;
    bem       = NB'(8'h01);
    wdata_rep = {NB{in_wdata[7:0]}};
    case (in_size)
      2'b00: ;
      2'b01: begin
        illegal   = illegal | in_addr[0];
        bem       = NB'(8'h03);
        wdata_rep = {(NB/2){in_wdata[15:0]}};
      end
      2'b10: begin
        illegal   = illegal | (in_addr[1:0] != 2'b00);
        bem       = NB'(8'h0F);
        wdata_rep = {(NB/4){in_wdata[31:0]}};
      end
      default: begin
        illegal   = illegal | (DATA_W == 32) | (in_addr[2:0] != 3'b000);
        bem       = NB'(8'hFF);
        wdata_rep = in_wdata;
      end
    endcase
  end

  // Load alignment: shift the addressed lane down, then sign/zero fill above the element
  always_comb begin
    shifted = mem_rsp_rdata >> {op_addr[LW-1:0], 3'b000};
    case (op_size)
      2'b00:   begin keep = DATA_W'(8'hFF);         sbit = shifted[7];        end
      2'b01:   begin keep = DATA_W'(16'hFFFF);      sbit = shifted[15];       end
      2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); sbit = shifted[31];       end
      default: begin keep = '1;                     sbit = shifted[DATA_W-1]; end
    endcase
    ld_ext = (shifted & keep) | ({DATA_W{op_signed & sbit}} & ~keep);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid && tag_ok && !is_nop) state_nxt = illegal ? S_FAULT : S_REQ;
      S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
               else if (tmo_hit)  state_nxt = S_FAULT;
      S_WAIT:  if (mem_rsp_valid) state_nxt = mem_rsp_err ? S_FAULT : S_IDLE;
               else if (tmo_hit)  state_nxt = S_FAULT;
      S_FAULT: if (fault_clr) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_addr    <= '0;
      op_be      <= '0;
      op_wdata   <= '0;
      op_we      <= 1'b0;
      op_size    <= 2'b00;
      op_signed  <= 1'b0;
      op_rd      <= '0;
      tmo_cnt    <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      fault_code <= 2'b00;
      fault_addr <= '0;
    end else begin
      state    <= state_nxt;
      wb_valid <= 1'b0;
      if (state == S_IDLE && state_nxt == S_REQ) begin
        op_addr   <= in_addr;
        op_be     <= bem << in_addr[LW-1:0];
        op_wdata  <= wdata_rep;
        op_we     <= in_store;
        op_size   <= in_size;
        op_signed <= in_signed;
        op_rd     <= in_rd;
        tmo_cnt   <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state != S_FAULT && state_nxt == S_FAULT) begin
        fault_addr <= (state == S_IDLE) ? in_addr : op_addr;
        if (state == S_IDLE)                    fault_code <= 2'b01;
        else if (mem_rsp_valid && state == S_WAIT) fault_code <= 2'b10;
        else                                    fault_code <= 2'b11;
      end
      if (state == S_FAULT && fault_clr) fault_code <= 2'b00;
      if (state == S_WAIT && mem_rsp_valid && !mem_rsp_err && !op_we) begin
        wb_valid <= 1'b1;
        wb_rd    <= op_rd;
        wb_data  <= ld_ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_load, in_store, in_signed;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_rd;
  logic        in_branch_ref, branch_ref_global;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, fault, fault_clr;
  logic [1:0]  fault_code;
  logic [31:0] fault_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .RD_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_branch_ref(in_branch_ref), .branch_ref_global(branch_ref_global),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .fault(fault), .fault_code(fault_code), .fault_addr(fault_addr), .fault_clr(fault_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic bref);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_signed = sg;
    in_addr = a; in_wdata = wd; in_rd = 4'd7; in_branch_ref = bref;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] rdat, input logic [31:0] exp_data,
                         input logic [3:0] exp_be);
    issue(1'b1, 1'b0, sz, sg, a, 32'h0, 1'b0);
    chk({tag, "_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_req_valid"}, mem_req_valid, 1);
    chk({tag, "_req_addr"}, mem_req_addr, a & 32'hFFFF_FFFC);
    chk({tag, "_be"}, mem_req_be, exp_be);
    chk({tag, "_we"}, mem_req_we, 0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdat;
    tick();
    mem_rsp_valid = 1'b0;
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_wb_data"}, wb_data, exp_data);
    chk({tag, "_wb_rd"}, wb_rd, 4'd7);
    chk({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'b00;
    in_signed = 1'b0; in_addr = '0; in_wdata = '0; in_rd = '0; in_branch_ref = 1'b0;
    branch_ref_global = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0; mem_rsp_err = 1'b0; fault_clr = 1'b0;
    tick(); tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_code", fault_code, 0);
    chk("rst_fault_addr", fault_addr, 0);
    rst_n = 1'b1;
    tick();

    do_load("ldrb_s",  32'h103, 2'b00, 1'b1, 32'h8011_2233, 32'hFFFF_FF80, 4'b1000);
    tick();
    chk("wb_pulse_1cyc", wb_valid, 0);
    do_load("ldrh_u",  32'h102, 2'b01, 1'b0, 32'hABCD_0000, 32'h0000_ABCD, 4'b1100);
    do_load("ldrh_s",  32'h102, 2'b01, 1'b1, 32'hABCD_0000, 32'hFFFF_ABCD, 4'b1100);
    do_load("ldr",     32'h104, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
    do_load("ldrb_u",  32'h101, 2'b00, 1'b0, 32'h0000_F100, 32'h0000_00F1, 4'b0010);

    // STRH
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_1234, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("strh_valid", mem_req_valid, 1);
    chk("strh_be", mem_req_be, 4'b1100);
    chk("strh_wdata", mem_req_wdata, 32'h1234_1234);
    chk("strh_we", mem_req_we, 1);
    chk("strh_addr", mem_req_addr, 32'h100);
    tick();
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    chk("strh_no_wb", wb_valid, 0);
    chk("strh_idle", in_ready, 1);

    // Back-pressure: request held stable, upstream stalled
    mem_req_ready = 1'b0;
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h001, 32'h0, 1'b0);
    tick();
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h440, 32'h5555_5555, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), mem_req_valid, 1);
      chk($sformatf("bp_addr_%0d", i), mem_req_addr, 32'h000);
      chk($sformatf("bp_be_%0d", i), mem_req_be, 4'b0010);
      chk($sformatf("bp_stall_%0d", i), stall, 1);
      tick();
    end
    mem_req_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("bp_handshake_done", mem_req_valid, 0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0000_7F00;
    tick();
    mem_rsp_valid = 1'b0;
    chk("bp_wb_valid", wb_valid, 1);
    chk("bp_wb_data", wb_data, 32'h0000_007F);

    // Branch squash, then immediate next op
    branch_ref_global = 1'b1;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0);
    tick();
    chk("squash_no_req", mem_req_valid, 0);
    chk("squash_ready", in_ready, 1);
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AB, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("post_squash_req", mem_req_valid, 1);
    chk("strb_be", mem_req_be, 4'b0010);
    chk("strb_wdata", mem_req_wdata, 32'hABAB_ABAB);
    tick();
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    branch_ref_global = 1'b0;

    // No-op is consumed without a request
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("nop_no_req", mem_req_valid, 0);
    chk("nop_ready", in_ready, 1);

    // Misaligned word load
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mis_fault", fault, 1);
    chk("mis_code", fault_code, 2'b01);
    chk("mis_addr", fault_addr, 32'h102);
    chk("mis_no_req", mem_req_valid, 0);
    chk("mis_not_ready", in_ready, 0);
    tick();
    chk("mis_sticky", fault, 1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault", fault, 0);
    chk("clr_code", fault_code, 0);
    chk("clr_ready", in_ready, 1);

    // Dword on a 32-bit bus is illegal
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h000, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("dword_code", fault_code, 2'b01);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;

    // Bus error on a load
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h208, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    chk("berr_code", fault_code, 2'b10);
    chk("berr_addr", fault_addr, 32'h208);
    chk("berr_no_wb", wb_valid, 0);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;

    // Timeout: fault lands 8 cycles after REQ entry
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_not_yet", fault, 0);
    tick();
    chk("tmo_fault", fault, 1);
    chk("tmo_code", fault_code, 2'b11);
    chk("tmo_addr", fault_addr, 32'h300);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;

    // Response in the timeout cycle wins
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h30C, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h1357_9BDF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("race_no_fault", fault, 0);
    chk("race_wb", wb_valid, 1);
    chk("race_wb_data", wb_data, 32'h1357_9BDF);

    // Reset mid-WAIT abandons the transaction
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h310, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_req", mem_req_valid, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    chk("mid_rst_fault_addr", fault_addr, 0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray_rsp_ignored", wb_valid, 0);
    chk("stray_rsp_idle", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
